// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared widths, port indices and arbiter FSM states for the nrisc data path
package nrisc_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO = 1'b1;
  typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/nrisc_arb_pick.sv
// nrisc_arb_pick: 2-way winner selector; round-robin under NRISC_DATA_ARB_RR_EN, else fixed CPU priority
module nrisc_arb_pick
  import nrisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_elig,
  output logic       o_valid,
  output logic       o_win
);
`ifdef NRISC_DATA_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif
  logic r_last;
  assign o_valid = |i_elig;
  // On a tie the port not granted last wins; reset leaves IO as "last" so CPU goes first
  assign o_win = &i_elig ? RR & ~r_last : i_elig[PORT_IO];
  always_ff @(posedge clk) begin
    if (rst) r_last <= PORT_IO;
    else if (o_valid) r_last <= o_win;
  end
endmodule

// File: rtl/nrisc_data_arbiter.sv
// nrisc_data_arbiter: CPU/IO arbiter onto one single-cycle data memory port
// Round-robin tie-break when NRISC_DATA_ARB_RR_EN is defined, fixed CPU priority otherwise
module nrisc_data_arbiter
  import nrisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t r_state;
  logic r_cpu_gnt, r_io_gnt, r_cpu_rvalid, r_io_rvalid, r_we, r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic w_valid, w_win;
  // A port holding gnt this cycle is presenting a stale command, so it sits out
  wire [1:0] w_elig = {io_req & ~r_io_gnt, cpu_req & ~r_cpu_gnt};
  nrisc_arb_pick u_pick (
    .clk(clk),
    .rst(rst),
    .i_elig(w_elig),
    .o_valid(w_valid),
    .o_win(w_win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cpu_gnt <= 1'b0;
      r_io_gnt <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_io_rvalid <= 1'b0;
      r_we <= 1'b0;
      r_owner <= PORT_CPU;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_cpu_rvalid <= r_state == ACCESS && !r_we && r_owner == PORT_CPU;
      r_io_rvalid <= r_state == ACCESS && !r_we && r_owner == PORT_IO;
      r_cpu_gnt <= w_valid && w_win == PORT_CPU;
      r_io_gnt <= w_valid && w_win == PORT_IO;
      r_state <= w_valid ? ACCESS : IDLE;
      r_we <= w_valid && (w_win ? io_we : cpu_we);
      if (w_valid) begin
        r_owner <= w_win;
        r_addr <= w_win ? io_addr : cpu_addr;
        r_wdata <= w_win ? io_wdata : cpu_wdata;
      end
    end
  end
  assign cpu_gnt = r_cpu_gnt;
  assign io_gnt = r_io_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign io_rvalid = r_io_rvalid;
  assign mem_en = r_state == ACCESS;
  assign mem_we = r_we;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata = mem_rdata;
endmodule

// File: tb/tb_nrisc_data_arbiter.sv
// tb_nrisc_data_arbiter: directed bench with a cycle-level arbitration model and a bench-side memory
module tb_nrisc_data_arbiter;
`ifdef NRISC_DATA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 0, cpu_we = 0, io_req = 0, io_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, io_addr = 0, io_wdata = 0;
  logic cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:65535];
  logic [15:0] xmem [0:65535];
  int checks = 0, errors = 0;
  bit chk_on = 0;
  bit e_cg = 0, e_ig = 0, e_en = 0, e_we = 0, e_crv = 0, e_irv = 0;
  int e_own = 0, last = 1;
  logic [15:0] e_addr = 0, e_wdata = 0, e_rdata = 0;

  always #5 clk = ~clk;

  nrisc_data_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  // Model: one access per cycle, a port just granted sits out, ties go to CPU (fixed) or the other port (RR)
  always @(posedge clk) begin
    bit ce, ie;
    int w;
    if (rst) begin
      {e_cg, e_ig, e_en, e_we, e_crv, e_irv} = '0;
      e_addr = 0;
      e_wdata = 0;
      last = 1;
    end else begin
      e_crv = e_en && !e_we && e_own == 0;
      e_irv = e_en && !e_we && e_own == 1;
      if (e_en && !e_we) e_rdata = xmem[e_addr];
      if (e_en && e_we) xmem[e_addr] = e_wdata;
      ce = cpu_req && !e_cg;
      ie = io_req && !e_ig;
      w = (ce && ie) ? (RR ? 1 - last : 0) : (ie ? 1 : 0);
      e_en = ce || ie;
      e_cg = e_en && w == 0;
      e_ig = e_en && w == 1;
      e_we = e_en && (w == 1 ? io_we : cpu_we);
      if (e_en) begin
        e_own = w;
        last = w;
        e_addr = w == 1 ? io_addr : cpu_addr;
        e_wdata = w == 1 ? io_wdata : cpu_wdata;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_on) begin
      chk("cpu_gnt", cpu_gnt, e_cg);
      chk("io_gnt", io_gnt, e_ig);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("cpu_rvalid", cpu_rvalid, e_crv);
      chk("io_rvalid", io_rvalid, e_irv);
      if (e_en) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_crv || e_irv) chk("rdata", rdata, e_rdata);
    end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h1000 + 16'(i * 3);
      xmem[i] = 16'h1000 + 16'(i * 3);
    end
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("lit_rst_out", {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_en, mem_we}, 0);
    chk("lit_rst_addr", mem_addr, 0);
    chk("lit_rst_wdata", mem_wdata, 0);
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      chk("lit_idle", {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_en}, 0);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    @(negedge clk);
    chk("lit_rd_gnt", {cpu_gnt, io_gnt, mem_en}, 3'b101);
    chk("lit_rd_addr", mem_addr, 16'h0010);
    cpu_req = 0;
    @(negedge clk);
    chk("lit_rd_rvalid", cpu_rvalid, 1);
    chk("lit_rd_data", rdata, 16'h1030);
    io_req = 1; io_we = 1; io_addr = 16'h0020; io_wdata = 16'hBEEF;
    @(negedge clk);
    chk("lit_wr_gnt", {io_gnt, mem_we}, 2'b11);
    chk("lit_wr_data", mem_wdata, 16'hBEEF);
    io_req = 0; io_we = 0;
    @(negedge clk);
    chk("lit_wr_norv", {io_rvalid, mem_en}, 0);
    cpu_req = 1; cpu_addr = 16'h0020; io_req = 1; io_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lit_alt_gnt", {cpu_gnt, io_gnt, mem_en}, {i % 2 == 0, i % 2 == 1, 1'b1});
      if (i > 0) chk("lit_alt_rv", {cpu_rvalid, io_rvalid}, {i % 2 == 1, i % 2 == 0});
      if (i == 1) chk("lit_alt_beef", rdata, 16'hBEEF);
      if (i == 2) chk("lit_alt_io_data", rdata, 16'h1090);
    end
    cpu_req = 0; io_req = 0;
    @(negedge clk);
    cpu_req = 1; io_req = 1;
    @(negedge clk);
    chk("lit_tie_after_io", {cpu_gnt, io_gnt}, 2'b10);
    cpu_req = 0; io_req = 0;
    @(negedge clk);
    cpu_req = 1; io_req = 1;
    @(negedge clk);
    chk("lit_tie_after_cpu", {cpu_gnt, io_gnt}, RR ? 2'b01 : 2'b10);
    cpu_req = 0; io_req = 0;
    @(negedge clk);
    cpu_req = 1; cpu_addr = 16'h0010;
    @(negedge clk);
    chk("lit_rstrd_gnt", cpu_gnt, 1);
    rst = 1; cpu_req = 0;
    @(negedge clk);
    chk("lit_rstrd_out", {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_en, mem_we}, 0);
    chk("lit_rstrd_bus", {mem_addr, mem_wdata}, 0);
    rst = 0;
    @(negedge clk);
    chk("lit_rstrd_norv", cpu_rvalid, 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nrisc_data_arbiter.md
NRISC_DATA_ARBITER -- requirements
Module: nrisc_data_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the data bus width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the data-memory address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cpu_req, input, 1 bit: the CPU (port 0) access request.
REQ-006 SHALL have ports cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W): the CPU command.
REQ-007 SHALL have ports cpu_gnt (output, 1) and cpu_rvalid (output, 1): CPU grant pulse and CPU read-data-valid pulse.
REQ-008 SHALL have port io_req, input, 1 bit: the IO/DMA (port 1) access request.
REQ-009 SHALL have ports io_we (input, 1), io_addr (input, ADDR_W) and io_wdata (input, DATA_W): the IO command.
REQ-010 SHALL have ports io_gnt (output, 1) and io_rvalid (output, 1): IO grant pulse and IO read-data-valid pulse.
REQ-011 SHALL have port rdata, output, DATA_W: shared read data, equal to mem_rdata.
REQ-012 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): the memory command, all registered.
REQ-013 SHALL have port mem_rdata, input, DATA_W: memory data, valid one cycle after mem_en with mem_we=0.

Function
REQ-014 SHALL use FSM states IDLE (mem_en=0) and ACCESS (mem_en=1, owner register valid).
- IDLE -> ACCESS when any eligible request exists; ACCESS -> ACCESS on another eligible request; otherwise -> IDLE.
REQ-015 SHALL treat a port as eligible at a posedge when its req=1 and its gnt is not currently high.
- The same port can therefore never be granted on two consecutive cycles.
REQ-016 SHALL, on the posedge where a winner is chosen, register the following for the next cycle: winner gnt=1, mem_en=1, and mem_we/mem_addr/mem_wdata copied from the winner.
- Grant latency is 1 cycle after req is sampled.
REQ-017 SHALL pulse the owner's rvalid exactly one cycle after a read access cycle (mem_en=1, mem_we=0), with rdata=mem_rdata in that cycle.
- Writes produce no rvalid.
- Read latency is 2 cycles from req sampled.
REQ-018 SHALL sustain one access per cycle when both ports request, alternating owners.
- The rvalid of access N and mem_en of access N+1 may coincide.
REQ-019 SHALL rely on the requester protocol: req/we/addr/wdata held stable until the cycle gnt=1, and req dropped or a new command presented the cycle after gnt.
- Withdrawing req before gnt is allowed; the request is simply not served.
REQ-020 SHALL never have cpu_gnt and io_gnt high together, nor cpu_rvalid and io_rvalid high together.

Reset
REQ-021 SHALL, with rst=1 at a posedge, clear state to IDLE and drive cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_en, mem_we to 0 and mem_addr, mem_wdata to 0 in the following cycle.
REQ-022 SHALL abandon an access interrupted by reset mid-operation: any pending rvalid is suppressed.
REQ-023 SHALL reset the round-robin pointer to favour CPU (port 0) first.

Configuration
REQ-024 SHALL implement round-robin arbitration when NRISC_DATA_ARB_RR_EN is defined.
- On simultaneous eligibility, the port not granted most recently wins.
- The pointer updates on every grant.
REQ-025 SHALL implement fixed priority when NRISC_DATA_ARB_RR_EN is undefined.
- An eligible CPU always wins.
- IO is served only when the CPU is not eligible, e.g. on the alternate cycles forced by REQ-015.

Structure
REQ-026 SHALL take DATA_W/ADDR_W defaults, port-index constants (PORT_CPU=0, PORT_IO=1) and the FSM state enum from the shared package nrisc_pkg.
REQ-027 SHALL contain one sub-module, nrisc_arb_pick: a 2-way winner selector holding the RR pointer, which degenerates to fixed priority without the macro.

Verification
REQ-028 SHALL verify a CPU read: cpu_req=1, we=0, addr=0x0010 at edge E0 -> cpu_gnt and mem_en with mem_addr=0x0010 in cycle E0+1 -> cpu_rvalid=1 with rdata=memory[0x0010] in cycle E0+2.
REQ-029 SHALL verify an IO write: io_req=1, we=1, addr=0x0020, wdata=0xBEEF -> io_gnt, mem_we=1, mem_wdata=0xBEEF for one cycle, no io_rvalid, and a later read returns 0xBEEF.
REQ-030 SHALL verify simultaneous reads for 6 cycles, both reqs held -> grants alternate CPU, IO, CPU... (both RR and fixed builds), one mem_en per cycle, and rvalid follows each grant by 1 cycle.
REQ-031 SHALL verify the tie-break: simultaneous req after an IO grant -> CPU wins in both builds; simultaneous req after a CPU grant two cycles earlier -> IO wins with RR, CPU wins in the fixed build.
REQ-032 SHALL verify reset mid-read: rst=1 in the grant cycle of a read -> no rvalid follows, and all outputs are 0 the next cycle.
REQ-033 SHALL verify idle behaviour: no requests for 10 cycles -> mem_en=0 throughout, and no gnt or rvalid pulses.
